// File: rtl/core_desc_buffer_pkg.sv
// Shared widths and defaults for the core descriptor buffer.
// Also holds the type and wrap-around increment used by the lifetime push counters.
package core_desc_buffer_pkg;

    localparam int unsigned DEF_DESC_WIDTH = 64;
    localparam int unsigned DEF_IN_DEPTH   = 4;
    localparam int unsigned DEF_OUT_DEPTH  = 4;
    localparam int unsigned TOTAL_WIDTH    = 32;

    typedef logic [TOTAL_WIDTH-1:0] total_t;

    // Lifetime counters roll over from all-ones to zero.
    function automatic total_t total_inc(input total_t value);
        return value + total_t'(1);
    endfunction

endpackage

// File: rtl/core_desc_buffer_if.sv
// Descriptor handshakes between scheduler, buffer and core.
// The buffer uses the slave modport; the environment drives through master.
interface core_desc_buffer_if
    import core_desc_buffer_pkg::*;
#(
    parameter int unsigned DESC_WIDTH = DEF_DESC_WIDTH
);

    logic [DESC_WIDTH-1:0] s_in_desc;
    logic                  s_in_desc_valid;
    logic                  s_in_desc_ready;
    logic [DESC_WIDTH-1:0] core_in_desc;
    logic                  core_in_desc_valid;
    logic                  core_in_desc_taken;
    logic [DESC_WIDTH-1:0] core_out_desc;
    logic                  core_out_desc_valid;
    logic                  core_out_desc_taken;
    logic [DESC_WIDTH-1:0] m_out_desc;
    logic                  m_out_desc_valid;
    logic                  m_out_desc_ready;

    modport slave (
        input  s_in_desc,
        input  s_in_desc_valid,
        output s_in_desc_ready,
        output core_in_desc,
        output core_in_desc_valid,
        input  core_in_desc_taken,
        input  core_out_desc,
        input  core_out_desc_valid,
        output core_out_desc_taken,
        output m_out_desc,
        output m_out_desc_valid,
        input  m_out_desc_ready
    );

    modport master (
        output s_in_desc,
        output s_in_desc_valid,
        input  s_in_desc_ready,
        input  core_in_desc,
        input  core_in_desc_valid,
        output core_in_desc_taken,
        output core_out_desc,
        output core_out_desc_valid,
        input  core_out_desc_taken,
        input  m_out_desc,
        input  m_out_desc_valid,
        output m_out_desc_ready
    );

endinterface

// File: rtl/desc_fifo.sv
// First-word-fall-through FIFO with synchronous flush and occupancy count.
// Storage is unreset; the head reads zero whenever the FIFO is empty.
module desc_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_push_valid,
    output logic                   o_push_ready,
    output logic [WIDTH-1:0]       o_head_data,
    output logic                   o_head_valid,
    input  logic                   i_pop,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_push_fire
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = i_push_valid && !w_full;
    assign w_pop   = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush && !rst) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    assign o_push_ready = !w_full;
    assign o_head_valid = !w_empty && !rst;
    assign o_head_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_count      = r_wr_ptr - r_rd_ptr;
    assign o_push_fire  = w_push && !flush && !rst;

endmodule

// File: rtl/core_desc_buffer.sv
// Descriptor buffer between scheduler and core: an inbound and an outbound FWFT FIFO
// plus lifetime push counters that survive flush.
module core_desc_buffer
    import core_desc_buffer_pkg::*;
#(
    parameter int unsigned DESC_WIDTH = DEF_DESC_WIDTH,
    parameter int unsigned IN_DEPTH   = DEF_IN_DEPTH,
    parameter int unsigned OUT_DEPTH  = DEF_OUT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    core_desc_buffer_if.slave          desc_bus,
    output logic [$clog2(IN_DEPTH):0]  in_count,
    output logic [$clog2(OUT_DEPTH):0] out_count,
    output total_t                     in_total,
    output total_t                     out_total
);

    logic   w_in_push;
    logic   w_out_push;
    logic   w_out_ready;
    total_t r_in_total;
    total_t r_out_total;

    desc_fifo #(
        .WIDTH (DESC_WIDTH),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .i_push_data  (desc_bus.s_in_desc),
        .i_push_valid (desc_bus.s_in_desc_valid),
        .o_push_ready (desc_bus.s_in_desc_ready),
        .o_head_data  (desc_bus.core_in_desc),
        .o_head_valid (desc_bus.core_in_desc_valid),
        .i_pop        (desc_bus.core_in_desc_taken),
        .o_count      (in_count),
        .o_push_fire  (w_in_push)
    );

    desc_fifo #(
        .WIDTH (DESC_WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .i_push_data  (desc_bus.core_out_desc),
        .i_push_valid (desc_bus.core_out_desc_valid),
        .o_push_ready (w_out_ready),
        .o_head_data  (desc_bus.m_out_desc),
        .o_head_valid (desc_bus.m_out_desc_valid),
        .i_pop        (desc_bus.m_out_desc_ready),
        .o_count      (out_count),
        .o_push_fire  (w_out_push)
    );

    // Ready comes from registered full, so the scheduler's pop cannot reach taken.
    assign desc_bus.core_out_desc_taken = desc_bus.core_out_desc_valid && w_out_ready && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_total  <= '0;
            r_out_total <= '0;
        end else begin
            if (w_in_push) begin
                r_in_total <= total_inc(r_in_total);
            end
            if (w_out_push) begin
                r_out_total <= total_inc(r_out_total);
            end
        end
    end

    assign in_total  = r_in_total;
    assign out_total = r_out_total;

endmodule

// File: doc/core_desc_buffer.md
CORE_DESC_BUFFER -- requirements
Module: core_desc_buffer

Interface
REQ-001 SHALL have parameter DESC_WIDTH, default 64: descriptor width in bits.
REQ-002 SHALL have parameter IN_DEPTH, default 4: inbound FIFO entries, power of two, at least 2.
REQ-003 SHALL have parameter OUT_DEPTH, default 4: outbound FIFO entries, power of two, at least 2.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port flush, input, 1 bit: synchronous clear of both FIFOs; counters are not cleared.
REQ-008 SHALL have port s_in_desc, input, DESC_WIDTH bits: descriptor from the scheduler.
REQ-009 SHALL have port s_in_desc_valid, input, 1 bit: scheduler descriptor valid.
REQ-010 SHALL have port s_in_desc_ready, output, 1 bit: inbound FIFO can accept a descriptor.
REQ-011 SHALL have port core_in_desc, output, DESC_WIDTH bits: head of the inbound FIFO, to the core.
REQ-012 SHALL have port core_in_desc_valid, output, 1 bit: inbound FIFO is not empty.
REQ-013 SHALL have port core_in_desc_taken, input, 1 bit: core has consumed the head entry.
REQ-014 SHALL have port core_out_desc, input, DESC_WIDTH bits: descriptor written by the core.
REQ-015 SHALL have port core_out_desc_valid, input, 1 bit: both halves of the core descriptor have been written.
REQ-016 SHALL have port core_out_desc_taken, output, 1 bit: core descriptor accepted this cycle.
REQ-017 SHALL have port m_out_desc, output, DESC_WIDTH bits: head of the outbound FIFO, to the scheduler.
REQ-018 SHALL have port m_out_desc_valid, output, 1 bit: outbound FIFO is not empty.
REQ-019 SHALL have port m_out_desc_ready, input, 1 bit: scheduler accepts the outbound head.
REQ-020 SHALL have ports in_count and out_count, outputs, $clog2(DEPTH)+1 bits each: FIFO occupancy.
REQ-021 SHALL have ports in_total and out_total, outputs, 32 bits each: lifetime push counts.

Function
REQ-022 The inbound FIFO SHALL push when s_in_desc_valid and s_in_desc_ready are both high, and pop when core_in_desc_valid and core_in_desc_taken are both high.
REQ-023 The outbound FIFO SHALL push when core_out_desc_valid and core_out_desc_taken are both high, and pop when m_out_desc_valid and m_out_desc_ready are both high.
REQ-024 s_in_desc_ready SHALL equal (in_count != IN_DEPTH) and SHALL depend only on registered state.
REQ-025 core_out_desc_taken SHALL equal core_out_desc_valid AND (out_count != OUT_DEPTH), a single-cycle pulse per descriptor.
REQ-026 Both FIFOs SHALL be first-word-fall-through: an entry pushed at edge N appears at the head with valid high after edge N; head data SHALL be stable while valid is high and not popped.
REQ-027 When a FIFO is full, a same-cycle pop SHALL NOT enable a push; the push becomes possible the following cycle.
REQ-028 When a FIFO is non-empty and not full, a simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-029 A pop on an empty FIFO (taken or ready while valid is low) SHALL be ignored, with no change to pointers or count.
REQ-030 Pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full when the MSBs differ and the remaining bits are equal.
REQ-031 in_total and out_total SHALL increment by 1 per push and wrap from 0xFFFFFFFF to 0.
REQ-032 flush SHALL zero pointers and counts at the next edge, override same-cycle push and pop (the push is dropped, no counter increment), and leave the totals unchanged.
REQ-033 The FIFOs SHALL be independent; there is no ordering between inbound and outbound traffic.

Reset
REQ-034 During rst: counts, pointers, in_total and out_total SHALL be 0; s_in_desc_ready SHALL be 1; core_in_desc_valid, m_out_desc_valid and core_out_desc_taken SHALL be 0.
REQ-035 Reset mid-transfer SHALL discard all buffered descriptors; data outputs SHALL read 0 after reset until the first push.
REQ-036 Storage arrays SHALL NOT require reset.

Structure
REQ-037 A shared package SHALL hold DESC_WIDTH and the default depths.
REQ-038 One sub-module, desc_fifo (parameters WIDTH and DEPTH, with flush, count and FWFT head), SHALL be instantiated twice.
REQ-039 Storage SHALL infer distributed RAM or registers; there SHALL be no combinational path from m_out_desc_ready to core_out_desc_taken.

Verification
REQ-040 Reset, then push 0x11 to 0x44 inbound with core_in_desc_taken low -> in_count=4, ready=0; push 0x55 is refused; in_total=4.
REQ-041 From full, assert taken one cycle -> 0x11 popped, in_count=3; ready=1 the following cycle; order 0x22, 0x33, 0x44 preserved.
REQ-042 Outbound holds 2 entries; push and pop in the same cycle -> out_count stays 2; scheduler sees FIFO order.
REQ-043 Outbound full, core_out_desc_valid=1 -> taken=0 until m_out_desc_ready pops an entry, then taken pulses exactly one cycle.
REQ-044 Preload in_total=0xFFFFFFFF via a push loop or force, then one push -> in_total=0.
REQ-045 Three entries queued, flush asserted together with a push -> count=0, valid=0, push dropped, totals unchanged.
